io_write_endpoint: RTL and testbench
====================================

IO_WRITE_ENDPOINT -- requirements
Module: io_write_endpoint

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 36: width of one I/O write-port word.
REQ-002 SHALL have parameter DEPTH, default 8: buffer entries; legal range 2..256, need not be a power of two.
REQ-003 SHALL have parameter FULL_SLACK, default 0: free entries still held in reserve when full is reported; legal range 0..DEPTH-1.
REQ-004 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_wren  input  1  processor write-port enable, one word per asserted cycle.
REQ-007 SHALL have port in_data  input  WORD_WIDTH  processor write-port data.
REQ-008 SHALL have port in_EF  output  1  Full bit returned to the processor's I/O predication logic; 1 = do not write.
REQ-009 SHALL have port out_valid  output  1  head word present on out_data.
REQ-010 SHALL have port out_ready  input  1  external consumer accepts the head word.
REQ-011 SHALL have port out_data  output  WORD_WIDTH  head word.
REQ-012 SHALL have port count  output  clog2(DEPTH+1)  number of stored words.
REQ-013 SHALL have port overflow  output  1  sticky write-while-full error (present only with the macro of REQ-030).

Function
REQ-014 SHALL accept a write when in_wren=1 and count<DEPTH: store in_data at write pointer, advance write pointer.
REQ-015 SHALL pop the head when out_valid=1 and out_ready=1: advance read pointer.
REQ-016 SHALL decide write acceptance on pre-edge count only; a pop in the same cycle does not free a slot for that cycle's write.
REQ-017 SHALL, on simultaneous accepted write and pop, leave count unchanged.
REQ-018 SHALL, on in_wren=1 with count=DEPTH, drop the word and leave pointers and contents unchanged.
REQ-019 SHALL wrap each pointer from DEPTH-1 to 0 (modulo DEPTH, not modulo a power of two).
REQ-020 SHALL drive out_valid = (count!=0) and out_data = entry at read pointer, both from registered state, no combinational path from in_* or out_ready.
REQ-021 SHALL make a word written at edge N visible on out_data with out_valid=1 after edge N (latency one cycle); no bypass of an empty buffer.
REQ-022 SHALL drive in_EF = ((DEPTH-count) <= FULL_SLACK), from registered count only, so processor writes already in flight after in_EF rises land in the reserve.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL leave out_data undefined-but-stable (last read entry) when out_valid=0; checkers ignore it.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear both pointers and count to 0, drive out_valid=0, in_EF=0 (or 1 if FULL_SLACK>=DEPTH, disallowed), overflow=0.
REQ-026 SHALL discard all stored words on reset mid-operation; storage contents need not be cleared.
REQ-027 SHALL ignore in_wren and out_ready while reset_n is low; first accepted write is on the first rising edge with reset_n high.

Configuration
REQ-028 SHALL compile the overflow detector in or out with macro IO_WRITE_ENDPOINT_OVERFLOW_EN.
REQ-029 SHALL, with the macro defined, set overflow to 1 on any cycle meeting REQ-018 and hold it until reset.
REQ-030 SHALL, without the macro, omit the overflow port and its register entirely; all other behaviour identical.

Structure
REQ-031 SHALL place in shared package octavo_io_pkg: default word width (36), the counter-width function clog2, and the modulo-DEPTH pointer-increment function.
REQ-032 SHALL instantiate one sub-module io_fifo_ram: DEPTH x WORD_WIDTH storage, one synchronous write port, one asynchronous read port; pointers/count/flags stay in io_write_endpoint.

Verification
REQ-033 SHALL cover: DEPTH=8, slack 0, write 0x1,0x2,0x3 with out_ready=0 -> count=3, out_data=0x1; then out_ready=1 three cycles -> 0x1,0x2,0x3 in order, out_valid=0 after.
REQ-034 SHALL cover: fill 8 words -> in_EF=1 after 8th edge; 9th write 0xDEAD -> dropped, overflow=1 (macro on), drained data excludes 0xDEAD.
REQ-035 SHALL cover: count=8, in_wren=1 and out_ready=1 same cycle -> pop occurs, write dropped, count=7.
REQ-036 SHALL cover: FULL_SLACK=2, write 6 words -> in_EF=1 with count=6; 2 further writes accepted, count=8, overflow=0.
REQ-037 SHALL cover: DEPTH=5, 20 continuous write+read cycles -> pointer wraps 4->0, output sequence equals input sequence, count constant.
REQ-038 SHALL cover: reset_n pulsed low mid-cycle at count=4 -> out_valid, count, in_EF, overflow drop to 0 before next clock edge; next write appears as sole head word.

Source files
------------

// File: rtl/octavo_io_pkg.sv
// Shared constants and helpers for the Octavo I/O endpoints.
// Provides the default port word width, a ceil-log2 for sizing, and pointer wrap.
package octavo_io_pkg;

    localparam int DEFAULT_WORD_WIDTH = 36;

    // Returns ceil(log2(n)) for n >= 1 (clog2(1) = 0).
    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Depth need not be a power of two, so wrap explicitly at depth-1.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/io_write_endpoint_if.sv
// Processor write port and consumer handshake of the I/O write endpoint.
// The slave modport is the endpoint side, master is the processor/consumer side.
interface io_write_endpoint_if
    import octavo_io_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
);
    logic                  in_wren;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_EF;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_data;

    modport master (
        output in_wren, in_data, out_ready,
        input  in_EF, out_valid, out_data
    );

    modport slave (
        input  in_wren, in_data, out_ready,
        output in_EF, out_valid, out_data
    );
endinterface

// File: rtl/io_fifo_ram.sv
// Buffer storage for the I/O write endpoint: synchronous write, asynchronous read.
module io_fifo_ram #(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clock,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [WORD_WIDTH-1:0] rd_data_o
);
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/io_write_endpoint.sv
// Buffered processor I/O write port with early-full reporting to the predication logic.
// Define IO_WRITE_ENDPOINT_OVERFLOW_EN to build the sticky write-while-full overflow flag.
module io_write_endpoint
    import octavo_io_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int DEPTH      = 8,
    parameter int FULL_SLACK = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    io_write_endpoint_if.slave         bus,
    output logic [clog2(DEPTH+1)-1:0]  count
`ifdef IO_WRITE_ENDPOINT_OVERFLOW_EN
   ,output logic                       overflow
`endif
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_EF   = CNT_W'(DEPTH - FULL_SLACK);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_accept;
    logic             rd_accept;

    // Acceptance looks only at pre-edge count: a same-cycle pop never frees a slot.
    assign wr_accept = bus.in_wren && (count_q != CNT_FULL);
    assign rd_accept = bus.out_ready && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (rd_accept) begin
            rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    io_fifo_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clock      (clock),
        .wr_en_i    (wr_accept),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (bus.in_data),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (bus.out_data)
    );

    // Full is raised FULL_SLACK entries early so in-flight writes land in the reserve.
    assign bus.out_valid = (count_q != '0);
    assign bus.in_EF     = (count_q >= CNT_EF);
    assign count         = count_q;

`ifdef IO_WRITE_ENDPOINT_OVERFLOW_EN
    logic overflow_q, overflow_d;

    assign overflow_d = overflow_q | (bus.in_wren && (count_q == CNT_FULL));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif
endmodule

// File: tb/tb_io_write_endpoint.sv
// Bench for io_write_endpoint: three instances (8/slack0, 8/slack2, 5/slack0) against a queue model.
module tb_io_write_endpoint;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]        wren;
    logic [2:0][35:0]  wdata;
    logic [2:0]        rdy;
    logic [2:0]        valid;
    logic [2:0][35:0]  odata;
    logic [2:0][3:0]   cnt;
    logic [2:0]        ef;
`ifdef IO_WRITE_ENDPOINT_OVERFLOW_EN
    logic [2:0]        ovf;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 2) ? 5 : 8;
        localparam int S = (g == 1) ? 2 : 0;
        io_write_endpoint_if #(.WORD_WIDTH(36)) bus ();
        logic [$clog2(D+1)-1:0] c;
        io_write_endpoint #(.WORD_WIDTH(36), .DEPTH(D), .FULL_SLACK(S)) u_dut (
            .clock    (clk),
            .reset_n  (rst_n),
            .bus      (bus),
            .count    (c)
`ifdef IO_WRITE_ENDPOINT_OVERFLOW_EN
           ,.overflow (ovf[g])
`endif
        );
        assign bus.in_wren   = wren[g];
        assign bus.in_data   = wdata[g];
        assign bus.out_ready = rdy[g];
        assign valid[g]      = bus.out_valid;
        assign odata[g]      = bus.out_data;
        assign ef[g]         = bus.in_EF;
        assign cnt[g]        = 4'(c);
    end

    // Reference model: one queue per instance, rules applied directly.
    logic [35:0] mq [3][$];
    logic [2:0]  movf;
    int n_vec = 0;
    int n_err = 0;

    function automatic int depth_of(input int i);
        return (i == 2) ? 5 : 8;
    endfunction

    function automatic int slack_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int sz;
            sz = mq[i].size();
            chk(i, "count", 64'(cnt[i]), 64'(sz));
            chk(i, "out_valid", 64'(valid[i]), 64'(sz != 0));
            if (sz != 0) chk(i, "out_data", 64'(odata[i]), 64'(mq[i][0]));
            chk(i, "in_EF", 64'(ef[i]), 64'((depth_of(i) - sz) <= slack_of(i)));
`ifdef IO_WRITE_ENDPOINT_OVERFLOW_EN
            chk(i, "overflow", 64'(ovf[i]), 64'(movf[i]));
`endif
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        movf = '0;
    endtask

    task automatic step(input logic [2:0] wr, input logic [2:0][35:0] d, input logic [2:0] rd);
        @(negedge clk);
        wren  = wr;
        wdata = d;
        rdy   = rd;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            int  sz;
            logic acc, pop;
            sz  = mq[i].size();
            acc = wr[i] && (sz < depth_of(i));
            pop = rd[i] && (sz > 0);
            if (wr[i] && sz == depth_of(i)) movf[i] = 1'b1;
            if (pop) void'(mq[i].pop_front());
            if (acc) mq[i].push_back(d[i]);
        end
        #1;
        check_all();
    endtask

    task automatic step1(input int sel, input logic wr, input logic [35:0] d, input logic rd);
        logic [2:0]       w, r;
        logic [2:0][35:0] dd;
        w = '0; r = '0; dd = '0;
        w[sel]  = wr;
        r[sel]  = rd;
        dd[sel] = d;
        step(w, dd, r);
    endtask

    typedef struct {
        logic        wr;
        logic [35:0] d;
        logic        rd;
        logic [3:0]  e_cnt;
        logic        e_vld;
        logic [35:0] e_dat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 36'h1, 1'b0, 4'd1, 1'b1, 36'h1};
        tbl[1] = '{1'b1, 36'h2, 1'b0, 4'd2, 1'b1, 36'h1};
        tbl[2] = '{1'b1, 36'h3, 1'b0, 4'd3, 1'b1, 36'h1};
        tbl[3] = '{1'b0, 36'h0, 1'b1, 4'd2, 1'b1, 36'h2};
        tbl[4] = '{1'b0, 36'h0, 1'b1, 4'd1, 1'b1, 36'h3};
        tbl[5] = '{1'b0, 36'h0, 1'b1, 4'd0, 1'b0, 36'h0};

        // Reset with the write and ready inputs held active: nothing may be taken.
        model_reset();
        rst_n = 1'b0;
        wren  = '1;
        rdy   = '1;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        wren  = '0;
        rdy   = '0;
        rst_n = 1'b1;

        // Ordered write then drain through the vector table.
        foreach (tbl[k]) begin
            step1(0, tbl[k].wr, tbl[k].d, tbl[k].rd);
            chk(0, "tbl_count", 64'(cnt[0]), 64'(tbl[k].e_cnt));
            chk(0, "tbl_valid", 64'(valid[0]), 64'(tbl[k].e_vld));
            if (tbl[k].e_vld) chk(0, "tbl_data", 64'(odata[0]), 64'(tbl[k].e_dat));
        end

        // Fill to DEPTH, write while full, then write+pop at full.
        for (int k = 0; k < 8; k++) step1(0, 1'b1, 36'(10 + k), 1'b0);
        chk(0, "full_ef", 64'(ef[0]), 64'd1);
        step1(0, 1'b1, 36'hDEAD, 1'b0);
        chk(0, "drop_count", 64'(cnt[0]), 64'd8);
`ifdef IO_WRITE_ENDPOINT_OVERFLOW_EN
        chk(0, "drop_ovf", 64'(ovf[0]), 64'd1);
`endif
        step1(0, 1'b1, 36'hBEEF, 1'b1);
        chk(0, "full_wr_pop_count", 64'(cnt[0]), 64'd7);
        for (int k = 1; k < 8; k++) begin
            chk(0, "drain_data", 64'(odata[0]), 64'(10 + k));
            step1(0, 1'b0, 36'h0, 1'b1);
        end
        chk(0, "drained_valid", 64'(valid[0]), 64'd0);

        // Early full with two reserve entries.
        for (int k = 0; k < 6; k++) begin
            step1(1, 1'b1, 36'(20 + k), 1'b0);
            chk(1, "slack_ef", 64'(ef[1]), 64'(k == 5));
        end
        chk(1, "slack_count6", 64'(cnt[1]), 64'd6);
        step1(1, 1'b1, 36'd26, 1'b0);
        step1(1, 1'b1, 36'd27, 1'b0);
        chk(1, "slack_count8", 64'(cnt[1]), 64'd8);
`ifdef IO_WRITE_ENDPOINT_OVERFLOW_EN
        chk(1, "slack_ovf", 64'(ovf[1]), 64'd0);
`endif

        // Non-power-of-two depth: steady streaming forces repeated wraps.
        step1(2, 1'b1, 36'hA0, 1'b0);
        step1(2, 1'b1, 36'hA1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step1(2, 1'b1, 36'(100 + k), 1'b1);
            chk(2, "stream_count", 64'(cnt[2]), 64'd2);
        end

        // Asynchronous reset mid-cycle with four words stored.
        for (int k = 0; k < 4; k++) step1(0, 1'b1, 36'(40 + k), 1'b0);
        chk(0, "pre_rst_count", 64'(cnt[0]), 64'd4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        wren  = '0;
        rdy   = '0;
        model_reset();
        #1;
        check_all();
        chk(0, "rst_valid", 64'(valid[0]), 64'd0);
        chk(1, "rst_ef", 64'(ef[1]), 64'd0);
        #1;
        rst_n = 1'b1;
        step1(0, 1'b1, 36'h77, 1'b0);
        chk(0, "post_rst_count", 64'(cnt[0]), 64'd1);
        chk(0, "post_rst_data", 64'(odata[0]), 64'h77);

        // Random traffic, alternating fill-biased and drain-biased phases.
        for (int c = 0; c < 1500; c++) begin
            logic [2:0]       w, r;
            logic [2:0][35:0] d;
            int pw, pr;
            pw = ((c / 150) % 2 == 0) ? 75 : 30;
            pr = 105 - pw;
            for (int i = 0; i < 3; i++) begin
                w[i] = ($urandom_range(0, 99) < pw);
                r[i] = ($urandom_range(0, 99) < pr);
                d[i] = 36'({$urandom(), $urandom()});
            end
            step(w, d, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
